// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO slave: register offsets, decode width,
// bus handshake states and byte-lane helpers.
package wb_gpio_pkg;

  localparam int DEC_W = 3;

  localparam logic [7:0] GPIO_OUT        = 8'h00;
  localparam logic [7:0] GPIO_OUT_SET    = 8'h04;
  localparam logic [7:0] GPIO_OUT_CLR    = 8'h08;
  localparam logic [7:0] GPIO_OUT_TGL    = 8'h0C;
  localparam logic [7:0] GPIO_IN         = 8'h10;
  localparam logic [7:0] GPIO_IRQ_EN     = 8'h14;
  localparam logic [7:0] GPIO_IRQ_STATUS = 8'h18;
  localparam logic [7:0] GPIO_EDGE_CFG   = 8'h1C;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_t;

  function automatic logic [DEC_W-1:0] reg_idx(input logic [7:0] byte_off);
    return byte_off[DEC_W+1:2];
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // Rise enables live in [15:0], fall enables in [31:16]; only 16 inputs are configurable.
  function automatic logic [31:0] cfg_mask(input int nin);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < nin) begin
        m[i]      = 1'b1;
        m[16 + i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone bus bundle with 32-bit data, used between interconnect and slaves.
interface wb_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;
  logic        err;

  modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, stall, err);
  modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, stall, err);
endinterface

// File: rtl/wb_gpio_debounce.sv
// One input bit: synchroniser chain followed by a saturating stability counter.
// rise_o/fall_o pulse in the cycle where the debounced value is about to flip.
module gpio_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CW-1:0] LIM = (DEBOUNCE > 1) ? CW'(DEBOUNCE - 1) : '0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;
  logic                   flip;

  assign synced = sync_q[SYNC_STAGES-1];
  // With DEBOUNCE 0 or 1 the limit is zero, so any mismatch flips on the next edge.
  assign flip   = (synced != q_o) && (cnt_q == LIM);
  assign rise_o = flip & ~q_o;
  assign fall_o = flip & q_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      q_o    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      if ((synced == q_o) || flip) cnt_q <= '0;
      else                         cnt_q <= cnt_q + CW'(1);
      if (flip) q_o <= ~q_o;
    end
  end

endmodule

// File: rtl/wb_gpio.sv
// Wishbone GPIO slave: set/clear/toggle output register, debounced inputs with
// per-bit edge capture into sticky status flags, and a registered level interrupt.
module wb_gpio
  import wb_gpio_pkg::*;
#(
  parameter int              NOUT        = 4,
  parameter int              NIN         = 8,
  parameter int              SYNC_STAGES = 2,
  parameter int              DEBOUNCE    = 1_000_000,
  parameter logic [NOUT-1:0] OUT_RESET   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  wb_if.slave             wb,
  input  logic [NIN-1:0]  gpio_i,
  output logic [NOUT-1:0] gpio_o,
  output logic            irq_o
);

  localparam logic [DEC_W-1:0] A_OUT    = reg_idx(GPIO_OUT);
  localparam logic [DEC_W-1:0] A_SET    = reg_idx(GPIO_OUT_SET);
  localparam logic [DEC_W-1:0] A_CLR    = reg_idx(GPIO_OUT_CLR);
  localparam logic [DEC_W-1:0] A_TGL    = reg_idx(GPIO_OUT_TGL);
  localparam logic [DEC_W-1:0] A_IN     = reg_idx(GPIO_IN);
  localparam logic [DEC_W-1:0] A_EN     = reg_idx(GPIO_IRQ_EN);
  localparam logic [DEC_W-1:0] A_STATUS = reg_idx(GPIO_IRQ_STATUS);
  localparam logic [DEC_W-1:0] A_CFG    = reg_idx(GPIO_EDGE_CFG);
  localparam logic [31:0]      CFG_MASK = cfg_mask(NIN);

  bus_state_t       state_q, state_d;
  logic             accept, hit, wr;
  logic [DEC_W-1:0] off;
  logic [31:0]      wmask, wd, rdata, cfg_q, cfg_d;
  logic [NOUT-1:0]  out_q, out_d;
  logic [NIN-1:0]   in_db, rise, fall, rise_en, fall_en;
  logic [NIN-1:0]   en_q, en_d, status_q, status_d, w1c;
  logic             unused_adr;

  assign accept     = wb.cyc & wb.stb;
  assign off        = wb.adr[DEC_W+1:2];
  // The block owns a 256-byte window; offsets 0x20..0xFF inside it are unmapped.
  assign hit        = (wb.adr[7:5] == 3'b000);
  assign wr         = accept & wb.we & hit;
  assign wmask      = lane_mask(wb.sel);
  assign wd         = wb.dat_m & wmask;
  assign unused_adr = ^{wb.adr[31:8], wb.adr[1:0]};

  assign wb.stall = 1'b0;
  assign wb.err   = 1'b0;
  assign wb.ack   = (state_q == BUS_ACK);
  assign gpio_o   = out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BUS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = BUS_IDLE;
    if (accept) state_d = BUS_ACK;
  end

  for (genvar i = 0; i < NIN; i++) begin : g_in
    gpio_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (gpio_i[i]),
      .q_o    (in_db[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
    if (i < 16) begin : g_cfg
      assign rise_en[i] = cfg_q[i];
      assign fall_en[i] = cfg_q[16 + i];
    end else begin : g_nocfg
      assign rise_en[i] = 1'b0;
      assign fall_en[i] = 1'b0;
    end
  end

  always_comb begin
    out_d = out_q;
    en_d  = en_q;
    cfg_d = cfg_q;
    w1c   = '0;
    if (wr) begin
      case (off)
        A_OUT:    out_d = (out_q & ~wmask[NOUT-1:0]) | wd[NOUT-1:0];
        A_SET:    out_d = out_q | wd[NOUT-1:0];
        A_CLR:    out_d = out_q & ~wd[NOUT-1:0];
        A_TGL:    out_d = out_q ^ wd[NOUT-1:0];
        A_EN:     en_d  = (en_q & ~wmask[NIN-1:0]) | wd[NIN-1:0];
        A_STATUS: w1c   = wd[NIN-1:0];
        A_CFG:    cfg_d = ((cfg_q & ~wmask) | wd) & CFG_MASK;
        default:  ;
      endcase
    end
    // Hardware edge capture is OR-ed in after the clear, so a coincident set survives.
    status_d = (status_q & ~w1c) | (rise & rise_en) | (fall & fall_en);
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        A_OUT:    rdata[NOUT-1:0] = out_q;
        A_IN:     rdata[NIN-1:0]  = in_db;
        A_EN:     rdata[NIN-1:0]  = en_q;
        A_STATUS: rdata[NIN-1:0]  = status_q;
        A_CFG:    rdata           = cfg_q;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= OUT_RESET;
      en_q      <= '0;
      cfg_q     <= '0;
      status_q  <= '0;
      irq_o     <= 1'b0;
      wb.dat_s  <= '0;
    end else begin
      out_q    <= out_d;
      en_q     <= en_d;
      cfg_q    <= cfg_d;
      status_q <= status_d;
      irq_o    <= |(status_q & en_q);
      if (accept) wb.dat_s <= wb.we ? 32'h0 : rdata;
    end
  end

endmodule

// File: tb/tb_wb_gpio.sv
// Scoreboarded bench for wb_gpio: directed scenarios followed by randomized
// register traffic, checked against a register-map model kept in the bench.
module tb_wb_gpio;

  localparam int NOUT = 4;
  localparam int NIN  = 8;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic [NIN-1:0]  gpio_i = '0;
  logic [NOUT-1:0] gpio_o;
  logic            irq_o;

  wb_if bus();

  wb_gpio #(
    .NOUT        (NOUT),
    .NIN         (NIN),
    .SYNC_STAGES (2),
    .DEBOUNCE    (4),
    .OUT_RESET   (4'hA)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wb     (bus),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle = cycle + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [NOUT-1:0] m_out;
  logic [NIN-1:0]  m_in, m_en, m_status;
  logic [31:0]     m_cfg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic model_reset();
    m_out = 4'hA; m_en = '0; m_status = '0; m_cfg = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    if (adr[7:5] != 3'd0) return 32'h0;
    case (adr[4:2])
      3'd0:    return {28'h0, m_out};
      3'd4:    return {24'h0, m_in};
      3'd5:    return {24'h0, m_en};
      3'd6:    return {24'h0, m_status};
      3'd7:    return m_cfg;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] m, v;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{sel[b]}};
    v = d & m;
    if (adr[7:5] == 3'd0) begin
      case (adr[4:2])
        3'd0: m_out = (m_out & ~m[3:0]) | v[3:0];
        3'd1: m_out = m_out | v[3:0];
        3'd2: m_out = m_out & ~v[3:0];
        3'd3: m_out = m_out ^ v[3:0];
        3'd5: m_en  = (m_en & ~m[7:0]) | v[7:0];
        3'd6: m_status = m_status & ~v[7:0];
        3'd7: m_cfg = ((m_cfg & ~m) | v) & 32'h00FF_00FF;
        default: ;
      endcase
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the strobe.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp);
    exp_t e;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
    bus.adr = adr;  bus.dat_m = dat; bus.sel = sel;
    e.rd = !we; e.data = exp; e.cyc = cycle + 1;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0; bus.dat_m = '0; bus.sel = '0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    model_write(adr, d, sel);
    issue(1'b1, adr, d, sel, 32'h0);
  endtask

  task automatic rd(input logic [31:0] adr);
    issue(1'b0, adr, 32'h0, 4'hF, model_read(adr));
  endtask

  always @(negedge clk) begin
    if (bus.ack) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack=1, expected ack=0 (cycle %0d)", cycle);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_latency", cycle, e.cyc);
        check("err", {31'h0, bus.err}, 32'h0);
        check("stall", {31'h0, bus.stall}, 32'h0);
        if (e.rd) check("rdata", bus.dat_s, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    int acks;
    idle();
    model_reset();
    m_in = '0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_gpio_o", gpio_o, 4'hA);
    check("rst_irq", irq_o, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_dat_s", bus.dat_s, 0);
    gap(2);
    rst_n = 1'b1;
    gap(1);

    // 1: reset value readback
    rd(32'h00); idle(); gap(1);

    // 2: set/clear/toggle and lane gating
    wr(32'h00, 32'h3, 4'hF); check("out_wr", gpio_o, 4'h3);
    wr(32'h04, 32'hC, 4'hF); check("out_set", gpio_o, 4'hF);
    wr(32'h08, 32'h1, 4'hF); check("out_clr", gpio_o, 4'hE);
    wr(32'h0C, 32'h5, 4'hF); check("out_tgl", gpio_o, 4'hB);
    wr(32'h00, 32'h5, 4'h0); check("out_sel0", gpio_o, 4'hB);
    rd(32'h04); rd(32'h00); idle(); gap(1);

    // 3: glitch rejection, then exact debounce latency seen through back-to-back reads
    gpio_i[0] = 1'b1; gap(2); gpio_i[0] = 1'b0;
    gap(12);
    rd(32'h10); idle(); gap(1);
    gpio_i[0] = 1'b1;
    for (int k = 0; k < 8; k++) issue(1'b0, 32'h10, 32'h0, 4'hF, (k >= 6) ? 32'h1 : 32'h0);
    idle(); m_in[0] = 1'b1; gap(4);

    // 4: rise capture, irq timing, W1C, disabled fall edge
    wr(32'h1C, 32'h1, 4'hF); wr(32'h14, 32'h1, 4'hF); idle();
    gpio_i[0] = 1'b0; m_in[0] = 1'b0; gap(12);
    rd(32'h18); idle(); check("irq_idle", irq_o, 0);
    gap(1);
    gpio_i[0] = 1'b1; m_in[0] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); check("irq_same_cycle", irq_o, 0);
    @(negedge clk); check("irq_next_cycle", irq_o, 1);
    @(posedge clk); #1;
    m_status[0] = 1'b1;
    rd(32'h18); wr(32'h18, 32'h1, 4'hF); idle();
    gap(1); check("irq_cleared", irq_o, 0);
    gpio_i[0] = 1'b0; m_in[0] = 1'b0; gap(12);
    rd(32'h18); idle(); check("irq_after_fall", irq_o, 0);
    gap(1);

    // 5: W1C coinciding with a hardware rise: the set survives
    gpio_i[0] = 1'b1; m_in[0] = 1'b1;
    gap(5);
    wr(32'h18, 32'h1, 4'hF); m_status[0] = 1'b1; idle();
    gap(1); check("irq_set_wins", irq_o, 1);
    rd(32'h18); wr(32'h18, 32'h1, 4'hF); idle();
    gap(1); check("irq_cleared2", irq_o, 0);

    // 6: eight back-to-back strobes including unmapped offsets, then reset mid-burst
    rd(32'h00); wr(32'h04, 32'h1, 4'hF); rd(32'h08); rd(32'h10);
    rd(32'h14); rd(32'h20); wr(32'h20, 32'hFFFF_FFFF, 4'hF); rd(32'h1C);
    idle(); check("burst_out", gpio_o, m_out);
    gap(1);
    rd(32'h00); rd(32'h14); rd(32'h1C);
    rst_n = 1'b0; idle(); sb.delete(); model_reset();
    acks = 0;
    repeat (4) begin @(negedge clk); if (bus.ack) acks++; end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.ack) acks++; end
    check("ack_after_rst", acks, 0);
    @(posedge clk); #1;
    check("rst2_gpio_o", gpio_o, 4'hA);
    gap(12);
    rd(32'h18); idle(); gap(1);

    // Randomized register traffic with static inputs
    gpio_i = NIN'($urandom);
    gap(12); m_in = gpio_i;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      a = 32'($urandom_range(0, 9)) << 2;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        wr(a, d, s); check("rand_gpio_o", gpio_o, m_out);
      end else begin
        rd(a);
      end
      if ($urandom_range(0, 2) == 0) begin idle(); gap(1); end
    end
    idle(); gap(2);
    check("rand_irq", irq_o, |(m_status & m_en));
    gap(2);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
